// File: rtl/riscv_pkg.sv
// Shared definitions for the RV64 pipeline.
//   XLEN_DEFAULT  : default address/PC width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) inserted on flush
//   fetch_state_e : instruction-fetch FSM states
package riscv_pkg;

  localparam int XLEN_DEFAULT = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register between two stages (used here as IF/ID).
// Control priority: reset > flush > load > hold > bubble.
//   clk, reset       : clock, synchronous active-low reset
//   load             : capture {load_pc, load_instr} as a valid entry
//   flush            : discard contents (valid=0, instr=NOP)
//   hold             : keep current contents unchanged
//   (none asserted)  : bubble -- valid drops, pc/instr fields are kept
//   pc, instr, valid : registered contents presented to the next stage
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            hold,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // NOTE: reset is tested inside the clocked block, so it is synchronous;
  // every state update uses <= so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
      valid <= 1'b1;
    end else if (!hold) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests,
// keeps a one-entry hold buffer for responses that arrive while decode is
// stalled, and drives the IF/ID pipeline register.
//   clk, reset             : clock, synchronous active-low reset
//   branch_taken/_target   : redirect request from the branch comparator
//   stall                  : decode cannot accept this cycle
//   imem_req/_addr         : fetch request (addr is always the PC)
//   imem_rdata/_ready      : instruction response, same-cycle capable
//   if_id_pc/_instr/_valid : IF/ID register contents
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  fetch_state_e state, state_next;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;
  logic [XLEN-1:0] redirect_pc;

  logic pc_redirect, pc_advance, hold_we;
  logic ifid_load, ifid_flush, ifid_hold, ifid_from_hold;

  // Instructions are word aligned: the low two target bits are forced to 0.
  assign redirect_pc = branch_target & ~XLEN'(3);
  assign imem_addr   = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= BOOT;
    else        state <= state_next;
  end

  // Next-state logic. The hold buffer is full exactly when in HOLD, which
  // is also what suppresses new requests while it is occupied.
  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:  state_next = FETCH;
      FETCH: if (!branch_taken && stall && imem_ready) state_next = HOLD;
      HOLD:  if (branch_taken || !stall) state_next = FETCH;
      default: state_next = BOOT;
    endcase
  end

  // Output / datapath-control logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    imem_req       = 1'b0;
    pc_redirect    = 1'b0;
    pc_advance     = 1'b0;
    hold_we        = 1'b0;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_hold      = 1'b0;
    ifid_from_hold = 1'b0;
    unique case (state)
      BOOT: ifid_hold = 1'b1;
      FETCH: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          // Any same-cycle response belongs to the wrong path: ignore it.
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
          if (imem_ready) begin
            pc_advance = 1'b1;
            hold_we    = 1'b1;
          end
        end else if (imem_ready) begin
          pc_advance = 1'b1;
          ifid_load  = 1'b1;
        end
        // Not ready and not stalled: IF/ID falls through to a bubble.
      end
      HOLD: begin
        if (branch_taken) begin
          pc_redirect = 1'b1;
          ifid_flush  = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_load      = 1'b1;
          ifid_from_hold = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Program counter; the +4 wraps modulo 2^XLEN by construction.
  always_ff @(posedge clk) begin
    if (!reset)           pc <= RESET_PC;
    else if (pc_redirect) pc <= redirect_pc;
    else if (pc_advance)  pc <= pc + XLEN'(4);
  end

  // Hold buffer payload; occupancy is tracked by the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
    end else if (hold_we) begin
      hold_pc    <= pc;
      hold_instr <= imem_rdata;
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .hold       (ifid_hold),
    .load_pc    (ifid_from_hold ? hold_pc    : pc),
    .load_instr (ifid_from_hold ? hold_instr : imem_rdata),
    .pc         (if_id_pc),
    .instr      (if_id_instr),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns the low 32
// bits of the request address as the instruction word.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  int total;
  int passed;

  fetch_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid)
  );

  assign imem_rdata = imem_addr[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse, then leave the DUT in its first FETCH cycle (addr 0).
  task automatic restart();
    reset = 1'b0; branch_taken = 1'b0; branch_target = '0;
    stall = 1'b0; imem_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; branch_taken = 1'b0; branch_target = '0;
    stall = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    total++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", if_id_valid); else passed++;
    total++; if (if_id_instr !== NOP) $display("FAIL reset_instr: got %h expected %h", if_id_instr, NOP); else passed++;
    total++; if (if_id_pc !== 64'h0) $display("FAIL reset_ifid_pc: got %h expected 0", if_id_pc); else passed++;
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b expected 0", imem_req); else passed++;
    total++; if (imem_addr !== 64'h0) $display("FAIL reset_addr: got %h expected 0", imem_addr); else passed++;
    reset = 1'b1;
    // Cycle 0 after release is BOOT: still no request.
    total++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %0b expected 0", imem_req); else passed++;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL cycle1_req: got %0b expected 1", imem_req); else passed++;
    total++; if (if_id_valid !== 1'b0) $display("FAIL cycle1_valid: got %0b expected 0", if_id_valid); else passed++;
  endtask

  // Continues from test_reset: cycle 1, fetching address 0.
  task automatic test_free_run();
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (if_id_valid !== 1'b1) $display("FAIL run_valid[%0d]: got %0b expected 1", k, if_id_valid); else passed++;
      total++; if (if_id_pc !== 64'(4 * k)) $display("FAIL run_pc[%0d]: got %h expected %h", k, if_id_pc, 64'(4 * k)); else passed++;
      total++; if (if_id_instr !== 32'(4 * k)) $display("FAIL run_instr[%0d]: got %h expected %h", k, if_id_instr, 32'(4 * k)); else passed++;
    end
    total++; if (imem_addr !== 64'h18) $display("FAIL run_addr: got %h expected 18", imem_addr); else passed++;
  endtask

  task automatic test_branch();
    restart();
    tick(); tick(); tick(); tick();   // IF/ID holds pc 0xC, fetching 0x10
    total++; if (imem_addr !== 64'h10) $display("FAIL br_pre_addr: got %h expected 10", imem_addr); else passed++;
    branch_taken = 1'b1; branch_target = 64'h103;   // low bits must be ignored
    tick();
    branch_taken = 1'b0;
    total++; if (if_id_valid !== 1'b0) $display("FAIL br_bubble_valid: got %0b expected 0", if_id_valid); else passed++;
    total++; if (if_id_instr !== NOP) $display("FAIL br_bubble_instr: got %h expected %h", if_id_instr, NOP); else passed++;
    total++; if (imem_addr !== 64'h100) $display("FAIL br_addr: got %h expected 100", imem_addr); else passed++;
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h100 || if_id_instr !== 32'h100)
      $display("FAIL br_target_entry: got v=%0b pc=%h i=%h expected v=1 pc=100 i=100", if_id_valid, if_id_pc, if_id_instr); else passed++;
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h104)
      $display("FAIL br_next_entry: got v=%0b pc=%h expected v=1 pc=104", if_id_valid, if_id_pc); else passed++;
  endtask

  task automatic test_stall();
    restart();
    tick();                          // IF/ID pc 0, fetching 4
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0 || if_id_instr !== 32'h0)
        $display("FAIL stall_frozen[%0d]: got v=%0b pc=%h i=%h expected v=1 pc=0 i=0", k, if_id_valid, if_id_pc, if_id_instr); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d]: got %0b expected 0", k, imem_req); else passed++;
      total++; if (imem_addr !== 64'h8) $display("FAIL stall_addr[%0d]: got %h expected 8", k, imem_addr); else passed++;
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'(4 + 4 * k) || if_id_instr !== 32'(4 + 4 * k))
        $display("FAIL stall_release[%0d]: got v=%0b pc=%h i=%h expected v=1 pc=%h", k, if_id_valid, if_id_pc, if_id_instr, 64'(4 + 4 * k)); else passed++;
    end
  endtask

  task automatic test_branch_in_hold();
    restart();
    tick();
    stall = 1'b1;
    tick();                          // HOLD with pc 4 buffered
    branch_taken = 1'b1; branch_target = 64'h200;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP)
      $display("FAIL hold_br_flush: got v=%0b i=%h expected v=0 i=%h", if_id_valid, if_id_instr, NOP); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 64'h200)
      $display("FAIL hold_br_addr: got req=%0b addr=%h expected req=1 addr=200", imem_req, imem_addr); else passed++;
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h200)
      $display("FAIL hold_br_entry: got v=%0b pc=%h expected v=1 pc=200", if_id_valid, if_id_pc); else passed++;
  endtask

  task automatic test_not_ready();
    restart();
    tick();                          // IF/ID pc 0, fetching 4
    imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (if_id_valid !== 1'b0 || if_id_pc !== 64'h0 || if_id_instr !== 32'h0)
        $display("FAIL nr_bubble[%0d]: got v=%0b pc=%h i=%h expected v=0 pc=0 i=0", k, if_id_valid, if_id_pc, if_id_instr); else passed++;
      total++; if (imem_addr !== 64'h4) $display("FAIL nr_addr[%0d]: got %h expected 4", k, imem_addr); else passed++;
    end
    imem_ready = 1'b1;
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h4 || if_id_instr !== 32'h4)
      $display("FAIL nr_resume: got v=%0b pc=%h i=%h expected v=1 pc=4 i=4", if_id_valid, if_id_pc, if_id_instr); else passed++;
  endtask

  task automatic test_reset_in_hold();
    restart();
    tick();
    stall = 1'b1;
    tick();                          // HOLD with pc 4 buffered
    reset = 1'b0;
    tick();
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 64'h0)
      $display("FAIL rh_ifid: got v=%0b pc=%h i=%h expected v=0 pc=0 i=%h", if_id_valid, if_id_pc, if_id_instr, NOP); else passed++;
    total++; if (imem_req !== 1'b0 || imem_addr !== 64'h0)
      $display("FAIL rh_pc: got req=%0b addr=%h expected req=0 addr=0", imem_req, imem_addr); else passed++;
    reset = 1'b1; stall = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || if_id_valid !== 1'b0)
      $display("FAIL rh_boot: got req=%0b v=%0b expected req=1 v=0", imem_req, if_id_valid); else passed++;
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0)
      $display("FAIL rh_first: got v=%0b pc=%h expected v=1 pc=0", if_id_valid, if_id_pc); else passed++;
  endtask

  task automatic test_pc_wrap();
    restart();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    total++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL wrap_pre: got %h expected fffffffffffffffc", imem_addr); else passed++;
    tick();
    total++; if (imem_addr !== 64'h0) $display("FAIL wrap_addr: got %h expected 0", imem_addr); else passed++;
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_id_instr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_entry: got v=%0b pc=%h i=%h expected v=1 pc=fffffffffffffffc", if_id_valid, if_id_pc, if_id_instr); else passed++;
    tick();
    total++; if (if_id_valid !== 1'b1 || if_id_pc !== 64'h0)
      $display("FAIL wrap_after: got v=%0b pc=%h expected v=1 pc=0", if_id_valid, if_id_pc); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_free_run();
    test_branch();
    test_stall();
    test_branch_in_hold();
    test_not_ready();
    test_reset_in_hold();
    test_pc_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
